// File: rtl/shift_if.sv
// shift_if: word handshake and serial link signals of the shift transmitter
interface shift_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             shift_en;
    logic             busy;
    logic             done;
    modport master (output data_in, load_valid, input load_ready, serial_out, shift_en, busy, done);
    modport slave  (input data_in, load_valid, output load_ready, serial_out, shift_en, busy, done);
endinterface

// File: rtl/shift_tx.sv
// shift_tx: parallel-in serial-out LSB-first transmitter with per-bit shift strobe
module shift_tx #(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 1
) (
    input logic   clk,
    input logic   rst_n,
    shift_if.slave bus
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    cyc_cnt;
    logic             last_cyc;
    logic             last_bit;
    logic             single;
    always_comb begin
        last_cyc = cyc_cnt == CW'(BIT_CYCLES - 1);
        last_bit = bit_cnt == BW'(WIDTH - 1);
        single   = BIT_CYCLES == 1;
    end
    // outputs are registered: each is set for the cycle the state is entering
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            sr             <= '0;
            bit_cnt        <= '0;
            cyc_cnt        <= '0;
            bus.load_ready <= 1'b1;
            bus.serial_out <= 1'b0;
            bus.shift_en   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.load_valid) begin
                    state          <= SEND;
                    sr             <= bus.data_in;
                    bit_cnt        <= '0;
                    cyc_cnt        <= '0;
                    bus.load_ready <= 1'b0;
                    bus.busy       <= 1'b1;
                    bus.serial_out <= bus.data_in[0];
                    bus.shift_en   <= single;
                end
                SEND: if (last_cyc) begin
                    sr      <= sr >> 1;
                    bit_cnt <= bit_cnt + BW'(1);
                    cyc_cnt <= '0;
                    if (last_bit) begin
                        state          <= DONE;
                        bus.done       <= 1'b1;
                        bus.serial_out <= 1'b0;
                        bus.shift_en   <= 1'b0;
                    end else begin
                        bus.serial_out <= sr[1];
                        bus.shift_en   <= single;
                    end
                end else begin
                    cyc_cnt      <= cyc_cnt + CW'(1);
                    bus.shift_en <= cyc_cnt + CW'(1) == CW'(BIT_CYCLES - 1);
                end
                DONE: begin
                    state          <= IDLE;
                    bus.done       <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.load_ready <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    bus.load_ready <= 1'b1;
                    bus.serial_out <= 1'b0;
                    bus.shift_en   <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.done       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_tx.sv
// tb_shift_tx: directed checks of shift_tx at BIT_CYCLES 1 and 3 with a looped-back receiver
module tb_shift_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int strobes1 = 0, strobes3 = 0, dones1 = 0;
    logic [3:0] rx1 = '0, rx3 = '0;
    always #5 clk = ~clk;
    shift_if #(.WIDTH(4)) b1 ();
    shift_if #(.WIDTH(4)) b3 ();
    shift_tx #(.WIDTH(4), .BIT_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    shift_tx #(.WIDTH(4), .BIT_CYCLES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    // receiver shifts high-to-low with serial_in entering at the MSB
    always_ff @(posedge clk) begin
        if (b1.shift_en === 1'b1) begin
            rx1      <= {b1.serial_out, rx1[3:1]};
            strobes1 <= strobes1 + 1;
        end
        if (b3.shift_en === 1'b1) begin
            rx3      <= {b3.serial_out, rx3[3:1]};
            strobes3 <= strobes3 + 1;
        end
        if (b1.done === 1'b1) dones1 <= dones1 + 1;
    end
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, b1.load_ready, 1);
        chk({tag, "_ser"}, b1.serial_out, 0);
        chk({tag, "_sen"}, b1.shift_en, 0);
        chk({tag, "_busy"}, b1.busy, 0);
        chk({tag, "_done"}, b1.done, 0);
    endtask
    initial begin
        int s, d;
        logic [3:0] w;
        b1.data_in = '0; b1.load_valid = 1'b0;
        b3.data_in = '0; b3.load_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
        chk_idle("rst");
        chk("rst3_ready", b3.load_ready, 1);
        chk("rst3_busy", b3.busy, 0);
        s = strobes1 + strobes3;
        tick(20);
        chk("idle_strobes", strobes1 + strobes3, s);
        // 4'b1011 at B=1
        w = 4'b1011; b1.data_in = w; b1.load_valid = 1'b1;
        tick();
        b1.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b1_ser%0d", i), b1.serial_out, w[i]);
            chk($sformatf("b1_sen%0d", i), b1.shift_en, 1);
            chk($sformatf("b1_busy%0d", i), b1.busy, 1);
            tick();
        end
        chk("b1_done", b1.done, 1);
        chk("b1_done_sen", b1.shift_en, 0);
        chk("b1_done_ready", b1.load_ready, 0);
        tick();
        chk("b1_ready_back", b1.load_ready, 1);
        chk("b1_rx", rx1, 4'b1011);
        // 4'hA at B=3
        w = 4'hA; b3.data_in = w; b3.load_valid = 1'b1;
        tick();
        b3.load_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("b3_ser_c%0d", c), b3.serial_out, w[(c - 1) / 3]);
            chk($sformatf("b3_sen_c%0d", c), b3.shift_en, (c % 3) == 0);
            tick();
        end
        chk("b3_done", b3.done, 1);
        chk("b3_done_sen", b3.shift_en, 0);
        tick();
        chk("b3_ready_back", b3.load_ready, 1);
        chk("b3_done_low", b3.done, 0);
        chk("b3_rx", rx3, 4'hA);
        // back-to-back 4'h5 then 4'hC with load_valid held high
        s = strobes1;
        b1.data_in = 4'h5; b1.load_valid = 1'b1;
        tick();
        b1.data_in = 4'hC;
        chk("bb_ser0", b1.serial_out, 1);
        tick(4);
        chk("bb_done1", b1.done, 1);
        chk("bb_rx1", rx1, 4'h5);
        tick();
        chk("bb_ready", b1.load_ready, 1);
        tick();
        b1.load_valid = 1'b0;
        chk("bb_busy2", b1.busy, 1);
        chk("bb2_ser0", b1.serial_out, 0);
        tick(4);
        chk("bb_done2", b1.done, 1);
        chk("bb_rx2", rx1, 4'hC);
        chk("bb_strobes", strobes1 - s, 8);
        tick();
        // load_valid during SEND is ignored
        b1.data_in = 4'h3; b1.load_valid = 1'b1;
        tick();
        b1.load_valid = 1'b0;
        tick();
        b1.data_in = 4'hF; b1.load_valid = 1'b1;
        chk("ign_ready", b1.load_ready, 0);
        tick();
        b1.load_valid = 1'b0;
        tick(2);
        chk("ign_done", b1.done, 1);
        chk("ign_ready_done", b1.load_ready, 0);
        chk("ign_rx", rx1, 4'h3);
        tick();
        chk("ign_ready_back", b1.load_ready, 1);
        tick();
        chk("ign_no_frame", b1.busy, 0);
        // reset after the 2nd strobe of 4'h9
        b1.data_in = 4'h9; b1.load_valid = 1'b1;
        tick();
        b1.load_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle("abort");
        s = strobes1; d = dones1;
        tick(6);
        chk("abort_strobes", strobes1, s);
        chk("abort_dones", dones1, d);
        b1.data_in = 4'h6; b1.load_valid = 1'b1;
        tick();
        b1.load_valid = 1'b0;
        tick(4);
        chk("post_done", b1.done, 1);
        chk("post_rx", rx1, 4'h6);
        tick();
        chk_idle("post");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
